// File: rtl/jk_sync_counter_pkg.sv
// Shared constants for the JK-based synchronous counter: direction codes,
// {J,K} excitation commands and default geometry.
package jk_sync_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD = 2'b00;
  localparam jk_cmd_t JK_CLR  = 2'b01;
  localparam jk_cmd_t JK_SET  = 2'b10;
  localparam jk_cmd_t JK_TOG  = 2'b11;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MODULO = 16;

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/data bundle of one counter stage; master drives controls, slave is the counter.
interface jk_sync_counter_if
  import jk_sync_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             Load;
  logic             En;
  logic             Up;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             Tc;

  modport master (output Load, output En, output Up, output D, input Q, input Tc);
  modport slave  (input Load, input En, input Up, input D, output Q, output Tc);
endinterface

// File: rtl/jk_cell.sv
// One JK storage bit, asynchronously cleared while Rst is low.
module jk_cell
  import jk_sync_counter_pkg::*;
(
  input  logic    Clk,
  input  logic    Rst,
  input  jk_cmd_t jk_i,
  output logic    q_o
);

  logic q_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      q_q <= 1'b0;
    end else begin
      case (jk_i)
        JK_SET:  q_q <= 1'b1;
        JK_CLR:  q_q <= 1'b0;
        JK_TOG:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULO up/down counter built from WIDTH JK cells; this level only
// forms the per-bit excitation and the terminal-count output.
module jk_sync_counter
  import jk_sync_counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MODULO = DEF_MODULO
) (
  input logic               Clk,
  input logic               Rst,
  jk_sync_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_VAL = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] target_d;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic             direct_d;
  logic             wrap_up;
  logic             wrap_down;

  // Out-of-range states (only reachable by load) take the wrap path in either direction.
  assign wrap_up   = (q_q >= TOP_VAL);
  assign wrap_down = (q_q == '0) || ({1'b0, q_q} >= MOD_VAL);

  always_comb begin
    direct_d = 1'b0;
    target_d = '0;
    if (bus.Load) begin
      direct_d = 1'b1;
      target_d = bus.D;
    end else if (bus.En && (bus.Up == DIR_UP) && wrap_up) begin
      direct_d = 1'b1;
      target_d = '0;
    end else if (bus.En && (bus.Up == DIR_DOWN) && wrap_down) begin
      direct_d = 1'b1;
      target_d = TOP_VAL;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_cmd_t jk_d;

      if (gi == 0) begin : g_lsb
        assign ones_below[gi]  = 1'b1;
        assign zeros_below[gi] = 1'b1;
      end else begin : g_upper
        assign ones_below[gi]  = &q_q[gi-1:0];
        assign zeros_below[gi] = ~|q_q[gi-1:0];
      end

      // Direct set/clear never emits J=K=1; toggling is reserved for plain binary steps.
      always_comb begin
        if (direct_d) begin
          jk_d = target_d[gi] ? JK_SET : JK_CLR;
        end else if (bus.En && (((bus.Up == DIR_UP) && ones_below[gi]) ||
                                ((bus.Up == DIR_DOWN) && zeros_below[gi]))) begin
          jk_d = JK_TOG;
        end else begin
          jk_d = JK_HOLD;
        end
      end

      jk_cell u_cell (
        .Clk  (Clk),
        .Rst  (Rst),
        .jk_i (jk_d),
        .q_o  (q_q[gi])
      );
    end
  endgenerate

  assign bus.Q  = q_q;
  assign bus.Tc = bus.En & (((bus.Up == DIR_UP) & (q_q == TOP_VAL)) |
                            ((bus.Up == DIR_DOWN) & (q_q == '0)));

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench: modulo-16, modulo-10 and a chained pair of counters checked against
// integer reference models every cycle, with directed and random stimulus.
module tb_jk_sync_counter;
  import jk_sync_counter_pkg::*;

  logic Clk;
  logic Rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  jk_sync_counter_if #(.WIDTH(4)) if_a  ();
  jk_sync_counter_if #(.WIDTH(4)) if_b  ();
  jk_sync_counter_if #(.WIDTH(4)) if_lo ();
  jk_sync_counter_if #(.WIDTH(4)) if_hi ();

  assign if_hi.En   = if_lo.Tc;
  assign if_hi.Up   = if_lo.Up;
  assign if_hi.Load = if_lo.Load;

  jk_sync_counter #(.WIDTH(4), .MODULO(16)) u_a  (.Clk(Clk), .Rst(Rst), .bus(if_a.slave));
  jk_sync_counter #(.WIDTH(4), .MODULO(10)) u_b  (.Clk(Clk), .Rst(Rst), .bus(if_b.slave));
  jk_sync_counter #(.WIDTH(4), .MODULO(16)) u_lo (.Clk(Clk), .Rst(Rst), .bus(if_lo.slave));
  jk_sync_counter #(.WIDTH(4), .MODULO(16)) u_hi (.Clk(Clk), .Rst(Rst), .bus(if_hi.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int step_ref(int q, bit ld, bit en, bit up, int d, int m);
    if (ld)  return d;
    if (!en) return q;
    if (up)  return (q >= m - 1) ? 0 : q + 1;
    return (q == 0 || q >= m) ? m - 1 : q - 1;
  endfunction

  function automatic int tc_ref(int q, bit en, bit up, int m);
    return (en && ((up && q == m - 1) || (!up && q == 0))) ? 1 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Chained pair modelled as one 8-bit up/down counter.
  int m_a, m_b, m_c;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_a <= 0;
      m_b <= 0;
      m_c <= 0;
    end else begin
      m_a <= step_ref(m_a, if_a.Load, if_a.En, if_a.Up, int'(if_a.D), 16);
      m_b <= step_ref(m_b, if_b.Load, if_b.En, if_b.Up, int'(if_b.D), 10);
      if (if_lo.Load)    m_c <= int'({if_hi.D, if_lo.D});
      else if (if_lo.En) m_c <= if_lo.Up ? (m_c + 1) % 256 : (m_c + 255) % 256;
    end
  end

  always @(negedge Clk) begin
    check("a_q",  int'(if_a.Q),  m_a);
    check("a_tc", int'(if_a.Tc), tc_ref(m_a, if_a.En, if_a.Up, 16));
    check("b_q",  int'(if_b.Q),  m_b);
    check("b_tc", int'(if_b.Tc), tc_ref(m_b, if_b.En, if_b.Up, 10));
    check("chain_q",  int'({if_hi.Q, if_lo.Q}), m_c);
    check("chain_tc", int'(if_hi.Tc), tc_ref(m_c, if_lo.En, if_lo.Up, 256));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    if_a.Load = 1'b0; if_a.En = 1'b1; if_a.Up = DIR_DOWN; if_a.D = 4'd0;
    if_b.Load = 1'b0; if_b.En = 1'b1; if_b.Up = DIR_DOWN; if_b.D = 4'd0;
    if_lo.Load = 1'b0; if_lo.En = 1'b1; if_lo.Up = DIR_UP; if_lo.D = 4'd0; if_hi.D = 4'd0;
    #1;
    check("rst_q",     int'(if_a.Q),  0);
    check("rst_tc_dn", int'(if_a.Tc), 1);
    if_a.Up = DIR_UP;
    #21;
    Rst = 1'b1;

    // a counts up through the wrap, b counts down mod 10, chain counts up.
    for (int k = 1; k <= 17; k++) begin
      tick();
      $display("up/down step %0d: a=%0d b=%0d chain=%0d", k, if_a.Q, if_b.Q, {if_hi.Q, if_lo.Q});
      check("up_seq",   int'(if_a.Q),  k % 16);
      check("up_tc",    int'(if_a.Tc), (k == 15) ? 1 : 0);
      check("down_seq", int'(if_b.Q),  (10 - (k % 10)) % 10);
      check("down_tc",  int'(if_b.Tc), (k % 10 == 0) ? 1 : 0);
      if (k == 16) check("chain_16", int'({if_hi.Q, if_lo.Q}), 16);
    end

    if_a.Load = 1'b1; if_a.D = 4'hC; if_a.En = 1'b1; if_a.Up = DIR_UP;
    if_b.Load = 1'b1; if_b.D = 4'd14; if_b.Up = DIR_UP;
    tick();
    check("load_wins", int'(if_a.Q), 12);
    check("load_oor",  int'(if_b.Q), 14);
    if_a.Load = 1'b0;
    if_b.Load = 1'b0;
    tick();
    check("after_load", int'(if_a.Q), 13);
    check("oor_up",     int'(if_b.Q), 0);
    if_a.Load = 1'b1; if_a.D = 4'd7;
    if_b.Load = 1'b1; if_b.D = 4'd14;
    tick();
    if_a.Load = 1'b0; if_a.En = 1'b0;
    if_b.Load = 1'b0; if_b.Up = DIR_DOWN;
    tick();
    check("oor_down", int'(if_b.Q), 9);

    for (int k = 0; k < 5; k++) begin
      if_a.Up = ~if_a.Up;
      if_a.D  = ~if_a.D;
      tick();
      $display("hold step %0d: a=%0d tc=%0d", k, if_a.Q, if_a.Tc);
      check("hold_q",  int'(if_a.Q),  7);
      check("hold_tc", int'(if_a.Tc), 0);
    end

    #3 Rst = 1'b0;
    #1;
    check("async_rst_a",     int'(if_a.Q), 0);
    check("async_rst_b",     int'(if_b.Q), 0);
    check("async_rst_chain", int'({if_hi.Q, if_lo.Q}), 0);
    #1 Rst = 1'b1;

    for (int k = 0; k < 400; k++) begin
      if_a.Load  = ($urandom_range(7) == 0);
      if_a.En    = ($urandom_range(3) != 0);
      if_a.Up    = 1'($urandom_range(1));
      if_a.D     = 4'($urandom_range(15));
      if_b.Load  = ($urandom_range(7) == 0);
      if_b.En    = ($urandom_range(3) != 0);
      if_b.Up    = 1'($urandom_range(1));
      if_b.D     = 4'($urandom_range(15));
      if_lo.Load = ($urandom_range(15) == 0);
      if_lo.En   = ($urandom_range(3) != 0);
      if_lo.Up   = 1'($urandom_range(1));
      if_lo.D    = 4'($urandom_range(15));
      if_hi.D    = 4'($urandom_range(15));
      tick();
      $display("rand %0d: a=%0d b=%0d chain=%0d", k, if_a.Q, if_b.Q, {if_hi.Q, if_lo.Q});
      if ($urandom_range(99) == 0) begin
        #2 Rst = 1'b0;
        #1 Rst = 1'b1;
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous modulo-N up/down counter whose state register is a row of JK flip-flop stages.
- A combinational excitation network computes per-bit J/K from the current count, mode and control inputs.
- Sits directly upstream of the JK storage cells. It is the design's first consumer-level sequential block built on JK storage: lab counters, timing dividers and sequence generators.

Parameters:
WIDTH, 4, count width in bits (2..8)
MODULO, 16, count modulus; legal range 2..2**WIDTH; state sequence is 0..MODULO-1

Ports:
Clk  input  1  clock; all state changes on rising edge
Rst  input  1  asynchronous, active-low reset; clock Clk
Load  input  1  synchronous parallel load; highest priority after reset
En  input  1  count enable
Up  input  1  direction: 1 = up, 0 = down
D  input  WIDTH  parallel load value
Q  output  WIDTH  current count (registered)
Tc  output  1  terminal count (combinational)

Behaviour:
- Reset: Rst low forces Q = 0 immediately, independent of Clk. Tc then follows its equation from Q = 0; e.g. Tc = 1 if En=1 and Up=0.
- Reset release: Rst rising between edges gives no state change until the next rising Clk. Rst asserted mid-count aborts the count and returns Q to 0.
- Priority per rising edge with Rst high:
  - Load = 1: Q <= D, regardless of En and Up.
  - Load = 0, En = 1, Up = 1: if Q >= MODULO-1 then Q <= 0, else Q <= Q+1.
  - Load = 0, En = 1, Up = 0: if Q == 0 or Q >= MODULO then Q <= MODULO-1, else Q <= Q-1.
  - Load = 0, En = 0: Q holds.
- Out-of-range load: D >= MODULO is loaded unmodified. The next enabled step applies the wrap rules above, so the counter always re-enters the legal range in one step.
- Latency: one clock from control or D to Q. No multi-cycle operation, no internal state beyond Q.
- Tc = En & ((Up & Q == MODULO-1) | (~Up & Q == 0)).
  - Tc is purely combinational from registered Q and the live inputs.
  - Tc is not gated by Load.
  - Intended use: chaining, where Tc of stage n drives En of stage n+1.
- Excitation rules:
  - Each bit i is stored in a JK stage.
  - Hold: J=K=0.
  - Toggle: J=K=1.
  - Load and wrap use set (J=1,K=0) or clear (J=0,K=1) per target bit.
  - Binary-count toggle condition for up: bit i toggles when all lower bits are 1; for down: when all lower bits are 0.
  - Wrap and load override the toggle pattern with direct set/clear of each bit toward the target value.
  - No J=K=1 is generated except for a genuine toggle.
- Simultaneous Load and terminal condition: Load wins, no wrap.
- Tc may still be 1 in that cycle.
- Up changed on the same edge as counting: the value sampled at that edge selects the direction.
- MODULO = 2**WIDTH: the wrap compare degenerates to natural binary overflow. Results must be identical.

Decomposition:
- Shared package holds:
  - mode encoding constants: DIR_UP = 1, DIR_DOWN = 0;
  - JK command constants: JK_HOLD = 2'b00, JK_CLR = 2'b01, JK_SET = 2'b10, JK_TOG = 2'b11, as {J,K};
  - the default WIDTH and MODULO.
- One sub-module, jk_cell: a single JK flip-flop bit with asynchronous active-low reset to 0.
- jk_sync_counter instantiates WIDTH copies of jk_cell and holds only the excitation and Tc logic.

Test Plan:
- Rst low at t=0, then released; En=1, Up=1, 17 edges -> Q steps 0,1,…,15,0. Tc=1 exactly while Q=15.
- MODULO=10: En=1, Up=0 from Q=0 -> Q=9,8,…,0,9. Tc=1 while Q=0.
- Load=1, D=4'hC, En=1, Up=1 on one edge -> Q=12, not 13. Next edge with Load=0 -> Q=13.
- MODULO=10: load D=14, then one up edge -> Q=0. Reload D=14, then one down edge -> Q=9.
- Q=7, En=0, toggle Up and D for 5 edges -> Q stays 7, Tc=0. Assert Rst low between edges -> Q=0 before the next edge.
- Two instances chained (Tc0 drives En1), WIDTH=4, Up=1 -> upper counter increments only on the edge where the lower counter wraps 15→0. The combined value reaches 8'h10 after 16 edges.
